fifo_ram_ctrl: RTL and testbench

Single-clock FIFO controller that drives a 64-entry, 8-bit dual-port RAM through the RAM's write and read ports. It owns the write pointer, read pointer, occupancy count, full/empty flags and error flags, and sits between a producer and consumer. Both RAM clocks are tied to `clk` at the level above. The RAM array is external; this block generates only addresses and enables, and returns RAM read data to the consumer.

---
 rtl/fifo_ram_ctrl_if.sv | 31 +++
 rtl/fifo_ram_ctrl.sv | 88 ++++++++
 tb/tb_fifo_ram_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ram_ctrl_if.sv
// Producer/consumer side of fifo_ram_ctrl: push/pop requests, read data and status flags.
interface fifo_ram_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 6
);
  // Handshake: push/pop are one-cycle requests with no ready wait. A push is taken
  // only if full was low at the start of the cycle, a pop only if empty was low.
  // pop_valid is high exactly one cycle after an accepted pop, and pop_data is
  // meaningful only while pop_valid is high.
  logic          push;
  logic [DW-1:0] push_data;
  logic          pop;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  modport master (
    output push, push_data, pop,
    input  pop_data, pop_valid, full, empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  push, push_data, pop,
    output pop_data, pop_valid, full, empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram_ctrl.sv
// Single-clock FIFO controller for an external dual-port RAM: owns pointers,
// occupancy, flags and sticky error bits; the RAM itself lives one level up.
module fifo_ram_ctrl #(
  parameter int DW       = 8,
  parameter int AW       = 6,
  parameter int AFULL_TH = 56
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_ram_ctrl_if.slave      fif,
  output logic                ram_wr_en,
  output logic [AW-1:0]       ram_wr_addr,
  output logic [DW-1:0]       ram_data,
  output logic [AW-1:0]       ram_rd_addr,
  input  logic [DW-1:0]       ram_q
);
  localparam int          DEPTH_I = 1 << AW;
  localparam logic [AW:0] DEPTH   = DEPTH_I[AW:0];
  localparam logic [AW:0] AFULL   = AFULL_TH[AW:0];
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_nxt;
  logic          full_q;
  logic          empty_q;
  logic          afull_q;
  logic          pop_valid_q;
  logic          overflow_q;
  logic          underflow_q;
  logic          push_ok;
  logic          pop_ok;

  // Acceptance uses the registered flags only, so a push on full is refused even
  // when a pop frees a slot in the same cycle; this keeps RAM addresses apart.
  assign push_ok = fif.push & ~full_q;
  assign pop_ok  = fif.pop & ~empty_q;

  always_comb begin
    count_nxt = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count_q + CNT_ONE;
      2'b01:   count_nxt = count_q - CNT_ONE;
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      count_q     <= count_nxt;
      full_q      <= (count_nxt == DEPTH);
      empty_q     <= (count_nxt == '0);
      afull_q     <= (count_nxt >= AFULL);
      pop_valid_q <= pop_ok;
      if (fif.push & full_q) overflow_q  <= 1'b1;
      if (fif.pop & empty_q) underflow_q <= 1'b1;
    end
  end

  assign ram_wr_en     = push_ok;
  assign ram_wr_addr   = wr_ptr;
  assign ram_data      = fif.push_data;
  assign ram_rd_addr   = rd_ptr;

  // The RAM registers its read data, so ram_q lines up with pop_valid.
  assign fif.pop_data    = ram_q;
  assign fif.pop_valid   = pop_valid_q;
  assign fif.full        = full_q;
  assign fif.empty       = empty_q;
  assign fif.almost_full = afull_q;
  assign fif.count       = count_q;
  assign fif.overflow    = overflow_q;
  assign fif.underflow   = underflow_q;
endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Bench for fifo_ram_ctrl with a behavioural registered-read RAM and a scoreboard.
module tb_fifo_ram_ctrl;
  logic       clk;
  logic       rst_n;
  logic       ram_wr_en;
  logic [5:0] ram_wr_addr;
  logic [7:0] ram_data;
  logic [5:0] ram_rd_addr;
  logic [7:0] ram_q;
  logic [7:0] mem [64];

  fifo_ram_ctrl_if #(.DW(8), .AW(6)) fif ();

  fifo_ram_ctrl #(.DW(8), .AW(6), .AFULL_TH(56)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fif         (fif),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_data    (ram_data),
    .ram_rd_addr (ram_rd_addr),
    .ram_q       (ram_q)
  );

  // clock / RAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_data;
    ram_q <= mem[ram_rd_addr];
  end

  // bench model state
  int         n_pass;
  int         n_total;
  int         m_count;
  logic [5:0] m_wr;
  logic [5:0] m_rd;
  logic       m_ovf;
  logic       m_unf;
  logic       m_pv;
  logic [7:0] m_fifo[$];
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_count = 0;
    m_wr    = '0;
    m_rd    = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_pv    = 1'b0;
    m_fifo.delete();
    exp_q.delete();
  endtask

  task automatic check_state();
    check("count",       32'(fif.count),       32'(m_count));
    check("empty",       32'(fif.empty),       32'(m_count == 0));
    check("full",        32'(fif.full),        32'(m_count == 64));
    check("almost_full", 32'(fif.almost_full), 32'(m_count >= 56));
    check("overflow",    32'(fif.overflow),    32'(m_ovf));
    check("underflow",   32'(fif.underflow),   32'(m_unf));
    check("pop_valid",   32'(fif.pop_valid),   32'(m_pv));
    check("ram_wr_addr", 32'(ram_wr_addr),     32'(m_wr));
    check("ram_rd_addr", 32'(ram_rd_addr),     32'(m_rd));
  endtask

  // driver: one cycle of push/pop, called at posedge+1, returns at next posedge+1
  task automatic op(input logic p, input logic [7:0] d, input logic q);
    bit pa;
    bit qa;
    fif.push      = p;
    fif.push_data = d;
    fif.pop       = q;
    pa = p && (m_count < 64);
    qa = q && (m_count > 0);
    @(posedge clk);
    #1;
    if (p && m_count == 64) m_ovf = 1'b1;
    if (q && m_count == 0)  m_unf = 1'b1;
    if (pa) begin
      m_fifo.push_back(d);
      m_wr = m_wr + 6'd1;
    end
    if (qa) begin
      exp_q.push_back(m_fifo.pop_front());
      m_rd = m_rd + 6'd1;
    end
    m_count = m_count + int'(pa) - int'(qa);
    m_pv    = qa;
    check_state();
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    fif.push = 1'b0;
    fif.pop  = 1'b0;
    model_reset();
    #1;
    check_state();
    check("ram_wr_en_rst", 32'(ram_wr_en), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    check("ram_wr_en", 32'(ram_wr_en), 32'(fif.push && (m_count < 64)));
    if (ram_wr_en) check("ram_data", 32'(ram_data), 32'(fif.push_data));
    if (fif.pop_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL pop_valid_unexpected: got data %0h expected no output at %0t", fif.pop_data, $time);
      end else begin
        check("pop_data", 32'(fif.pop_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0] dd;
    n_pass        = 0;
    n_total       = 0;
    rst_n         = 1'b0;
    fif.push      = 1'b0;
    fif.pop       = 1'b0;
    fif.push_data = '0;
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();

    // idle after reset
    for (int i = 0; i < 10; i++) op(1'b0, 8'h00, 1'b0);

    // fill with 0x01..0x40; almost_full and full boundaries come from check_state
    for (int i = 1; i <= 64; i++) begin
      dd = 8'(i);
      op(1'b1, dd, 1'b0);
    end
    check("full_at_64", 32'(fif.full), 32'd1);

    // push 0xAA on full together with a pop: push refused, oldest word popped
    op(1'b1, 8'hAA, 1'b1);
    check("count_after_ovf", 32'(fif.count), 32'd63);
    check("overflow_set",    32'(fif.overflow), 32'd1);

    // drain, crossing almost_full 56 -> 55
    for (int i = 0; i < 63; i++) op(1'b0, 8'h00, 1'b1);
    op(1'b0, 8'h00, 1'b0);
    check("empty_after_drain", 32'(fif.empty), 32'd1);

    // pop on empty together with push 0x55
    op(1'b1, 8'h55, 1'b1);
    check("underflow_set",  32'(fif.underflow), 32'd1);
    check("count_after_unf", 32'(fif.count), 32'd1);
    op(1'b0, 8'h00, 1'b1);
    op(1'b0, 8'h00, 1'b0);

    // wrap-around at count 10
    for (int i = 0; i < 10; i++) begin
      dd = 8'(8'h80 + i);
      op(1'b1, dd, 1'b0);
    end
    for (int i = 0; i < 200; i++) begin
      dd = 8'(i * 7 + 3);
      op(1'b1, dd, 1'b1);
    end
    check("count_after_wrap", 32'(fif.count), 32'd10);
    for (int i = 0; i < 10; i++) op(1'b0, 8'h00, 1'b1);
    op(1'b0, 8'h00, 1'b0);

    // almost_full from a fresh state, then reset with a pop in flight
    apply_reset();
    for (int i = 0; i < 57; i++) begin
      dd = 8'(8'hC0 + i);
      op(1'b1, dd, 1'b0);
    end
    op(1'b0, 8'h00, 1'b1);
    op(1'b0, 8'h00, 1'b1);
    check("afull_low_at_55", 32'(fif.almost_full), 32'd0);
    op(1'b0, 8'h00, 1'b1);
    apply_reset();
    check("pop_valid_dropped", 32'(fif.pop_valid), 32'd0);

    for (int i = 0; i < 3; i++) op(1'b0, 8'h00, 1'b0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
